// File: rtl/escalonador_chamadas.sv
// -----------------------------------------------------------------------------
// escalonador_chamadas
// Scheduler for a four-floor elevator. It collects hall and cabin calls in a
// pending-request bitmap. It chooses the travel direction, holds the cabin
// while the door cycles, and gives the floor controller the next target floor.
//
// Ports
//   clock_in          single clock, rising-edge active
//   reset_n           synchronous active-low reset
//   andar_atual       floor currently occupied by the cabin (0..3)
//   andar_chamada     hall-call floor selector
//   confirma_chamada  debounced level; rising edge registers a hall call
//   andar_pessoa      cabin-call floor selector
//   confirma_pessoa   debounced level; rising edge registers a cabin call
//   porta_aberta      door fully open
//   andar_proximo     target floor for the floor controller
//   parar_elevador    1 = cabin must hold at andar_atual
//   subindo           1 = travelling up
//   pedidos           pending-request bitmap, bit n = floor n
//   ocioso            1 = idle with no pending requests
// -----------------------------------------------------------------------------
module escalonador_chamadas #(
  parameter int TIMEOUT_PORTA = 15
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic [1:0] andar_atual,
  input  logic [1:0] andar_chamada,
  input  logic       confirma_chamada,
  input  logic [1:0] andar_pessoa,
  input  logic       confirma_pessoa,
  input  logic       porta_aberta,
  output logic [1:0] andar_proximo,
  output logic       parar_elevador,
  output logic       subindo,
  output logic [3:0] pedidos,
  output logic       ocioso
);

  typedef enum logic [2:0] {
    OCIOSO, SUBINDO, DESCENDO, ESPERA_PORTA, PORTA_ABERTA
  } estado_t;

  estado_t    estado, estado_prox;
  logic       chamada_q, pessoa_q;
  logic [3:0] pedidos_prox;
  logic [3:0] contador, contador_prox;
  logic [3:0] bit_aqui;
  logic       aqui, acima, abaixo, expirou;
  logic [1:0] alvo_acima, alvo_abaixo;
  logic [1:0] andar_proximo_d;
  logic       parar_d, subindo_d, ocioso_d;

  // Reselection after the door cycle or a door timeout. The cabin keeps its
  // last direction while there is work that way. It then prefers going down.
  // A request at the current floor only wins when no other floor is pending.
  function automatic estado_t reselecao(input logic ultimo_sobe,
                                        input logic tem_acima,
                                        input logic tem_abaixo,
                                        input logic tem_aqui);
    if (ultimo_sobe && tem_acima) return SUBINDO;
    else if (tem_abaixo)          return DESCENDO;
    else if (tem_acima)           return SUBINDO;
    else if (tem_aqui)            return ESPERA_PORTA;
    else                          return OCIOSO;
  endfunction

  // Request position relative to the cabin, plus the nearest target each way.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    bit_aqui    = 4'b0001 << andar_atual;
    aqui        = |(pedidos & bit_aqui);
    acima       = |(pedidos & ~((bit_aqui << 1) - 4'd1));
    abaixo      = |(pedidos & (bit_aqui - 4'd1));
    alvo_acima  = andar_atual;
    alvo_abaixo = andar_atual;
    // Descending scan: the last hit is the lowest floor above the cabin.
    for (int i = 3; i >= 0; i--)
      if (pedidos[i] && i > int'(andar_atual)) alvo_acima = 2'(i);
    // Ascending scan: the last hit is the highest floor below the cabin.
    for (int i = 0; i <= 3; i++)
      if (pedidos[i] && i < int'(andar_atual)) alvo_abaixo = 2'(i);
    expirou = (estado == ESPERA_PORTA) && !porta_aberta &&
              (contador >= 4'(TIMEOUT_PORTA - 1));
  end

  // Next-state logic
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO: begin
        if (aqui)        estado_prox = ESPERA_PORTA;
        else if (acima)  estado_prox = SUBINDO;
        else if (abaixo) estado_prox = DESCENDO;
      end
      SUBINDO, DESCENDO: begin
        if (aqui) estado_prox = ESPERA_PORTA;
      end
      ESPERA_PORTA: begin
        if (porta_aberta) estado_prox = PORTA_ABERTA;
        else if (expirou) estado_prox = reselecao(subindo, acima, abaixo, aqui);
      end
      PORTA_ABERTA: begin
        if (!porta_aberta) estado_prox = reselecao(subindo, acima, abaixo, aqui);
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // Request bitmap and door-wait counter
  always_comb begin
    pedidos_prox = pedidos;
    if (confirma_chamada && !chamada_q) pedidos_prox[andar_chamada] = 1'b1;
    if (confirma_pessoa  && !pessoa_q)  pedidos_prox[andar_pessoa]  = 1'b1;
    // While the door is open, the current floor is served and stays clear.
    if ((estado == ESPERA_PORTA || estado == PORTA_ABERTA) && porta_aberta)
      pedidos_prox[andar_atual] = 1'b0;

    contador_prox = contador;
    // A timeout that reselects back into ESPERA_PORTA counts as a new entry.
    if (estado_prox == ESPERA_PORTA && (estado != ESPERA_PORTA || expirou))
      contador_prox = 4'd0;
    else if (estado == ESPERA_PORTA && !porta_aberta &&
             contador != 4'(TIMEOUT_PORTA))
      contador_prox = contador + 4'd1;
  end

  // Output decode from the current state; registered below
  always_comb begin
    andar_proximo_d = andar_atual;
    parar_d         = 1'b1;
    subindo_d       = 1'b0;
    case (estado)
      SUBINDO: begin
        andar_proximo_d = alvo_acima;
        parar_d         = 1'b0;
        subindo_d       = 1'b1;
      end
      DESCENDO: begin
        andar_proximo_d = alvo_abaixo;
        parar_d         = 1'b0;
      end
      ESPERA_PORTA, PORTA_ABERTA: subindo_d = subindo;
      default: ;
    endcase
    ocioso_d = (estado == OCIOSO) && (pedidos == 4'b0000);
  end

  // State, request and output registers
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      estado         <= OCIOSO;
      pedidos        <= 4'b0000;
      contador       <= 4'd0;
      chamada_q      <= 1'b0;
      pessoa_q       <= 1'b0;
      andar_proximo  <= 2'd0;
      parar_elevador <= 1'b1;
      subindo        <= 1'b0;
      ocioso         <= 1'b1;
    end else begin
      estado         <= estado_prox;
      pedidos        <= pedidos_prox;
      contador       <= contador_prox;
      chamada_q      <= confirma_chamada;
      pessoa_q       <= confirma_pessoa;
      andar_proximo  <= andar_proximo_d;
      parar_elevador <= parar_d;
      subindo        <= subindo_d;
      ocioso         <= ocioso_d;
    end
  end

endmodule

// File: doc/escalonador_chamadas.md
ESCALONADOR_CHAMADAS -- requirements
Module: escalonador_chamadas

Interface
REQ-001 Parameter: TIMEOUT_PORTA, 15, clock_in cycles spent in ESPERA_PORTA without porta_aberta before forced reselection.
REQ-002 clock_in  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 andar_atual  input  2  floor currently occupied by the cabin (0..3).
REQ-005 andar_chamada  input  2  hall-call floor selector.
REQ-006 confirma_chamada  input  1  debounced level; its rising edge registers a hall call at andar_chamada.
REQ-007 andar_pessoa  input  2  cabin-call floor selector.
REQ-008 confirma_pessoa  input  1  debounced level; its rising edge registers a cabin call at andar_pessoa.
REQ-009 porta_aberta  input  1  door fully open.
REQ-010 andar_proximo  output  2  target floor for the floor controller.
REQ-011 parar_elevador  output  1  1 = cabin must hold at andar_atual.
REQ-012 subindo  output  1  1 = travel direction up, 0 = down or none.
REQ-013 pedidos  output  4  pending-request bitmap, bit n = floor n.
REQ-014 ocioso  output  1  1 = no pending requests and state OCIOSO.

Function
REQ-015 The block SHALL detect rising edges of confirma_chamada and confirma_pessoa using one registered copy of each; a held level registers only once.
REQ-016 An edge SHALL set pedidos[selector] on the following clock; edges on both inputs in the same cycle set both bits (same floor = one bit); setting an already-set bit has no further effect.
REQ-017 States: OCIOSO, SUBINDO, DESCENDO, ESPERA_PORTA, PORTA_ABERTA.
REQ-018 OCIOSO: pedidos[andar_atual]=1 -> ESPERA_PORTA; else any bit above -> SUBINDO; else any bit below -> DESCENDO; else stay.
REQ-019 SUBINDO/DESCENDO: pedidos[andar_atual]=1 -> ESPERA_PORTA; otherwise stay, with andar_proximo = nearest pending floor above (SUBINDO) or below (DESCENDO).
REQ-020 ESPERA_PORTA: porta_aberta=1 -> PORTA_ABERTA and clear pedidos[andar_atual] in the same cycle; TIMEOUT_PORTA cycles without porta_aberta -> reselection per REQ-022, bit kept.
REQ-021 PORTA_ABERTA: bit of andar_atual held clear (new requests for that floor ignored while porta_aberta=1); porta_aberta=0 -> reselection.
REQ-022 Reselection: last direction up and bits above -> SUBINDO; else bits below -> DESCENDO; else bits above -> SUBINDO; else OCIOSO. A bit at andar_atual set after the door closed -> ESPERA_PORTA.
REQ-023 parar_elevador=1 in OCIOSO, ESPERA_PORTA, PORTA_ABERTA; 0 in SUBINDO/DESCENDO.
REQ-024 andar_proximo = andar_atual in OCIOSO, ESPERA_PORTA, PORTA_ABERTA.
REQ-025 subindo=1 only in SUBINDO; it keeps its last value during ESPERA_PORTA/PORTA_ABERTA, 0 in OCIOSO and DESCENDO.
REQ-026 All outputs SHALL be registered; an output reflects a state change one clock after the transition clock.
REQ-027 Timeout counter 4 bits wide, cleared on every ESPERA_PORTA entry, saturates at TIMEOUT_PORTA.
REQ-028 andar_atual changes during SUBINDO/DESCENDO are taken as-is; no plausibility check.

Reset
REQ-029 reset_n=0 at a clock edge SHALL force: state OCIOSO, pedidos=0000, andar_proximo=00, parar_elevador=1, subindo=0, ocioso=1, edge registers=0, timeout counter=0.
REQ-030 Reset mid-travel or with door open SHALL discard all pending requests; edges coinciding with the reset clock are lost.
REQ-031 After reset release, the first request is accepted on the first rising edge of a confirm input.

Verification
REQ-032 Reset, andar_atual=0, rising edge confirma_chamada with andar_chamada=2 -> pedidos=0100, next clock SUBINDO: subindo=1, andar_proximo=2, parar_elevador=0.
REQ-033 Continue; andar_atual=2 -> parar_elevador=1; porta_aberta=1 -> pedidos=0000; porta_aberta=0 -> OCIOSO, ocioso=1.
REQ-034 andar_atual=1, cabin calls at 3 and 0 in the same cycle -> pedidos=1001, SUBINDO to 3; after door cycle at 3 -> DESCENDO, andar_proximo=0.
REQ-035 Held confirma_pessoa=1 for 50 cycles at floor 3 -> exactly one request set; clearing at 3 with level still high leaves it clear.
REQ-036 Call at andar_atual=1 while idle, porta_aberta held 0 -> after 15 cycles reselection returns to ESPERA_PORTA, pedidos[1] remains 1.
REQ-037 reset_n=0 during SUBINDO with pedidos=1010 -> next clock pedidos=0000, parar_elevador=1, subindo=0, ocioso=1.
